// File: rtl/stall_ctrl.sv
// stall_ctrl -- hazard and stall controller for the five-stage MIPS core.
//
// Decides each cycle whether PC and IF/ID advance and whether ID/EX gets a
// bubble. Register hazards use the Tuse/Tnew rule against the E and M stage
// destinations; mult/div hazards use a busy counter loaded when a mult/div
// instruction is in E. A saturating counter records stalled cycles.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   d_rs, d_rt          source register fields of the D-stage instruction
//   d_rs_tuse/d_rt_tuse Tuse of each source (3 = operand not read)
//   d_is_md             D instruction uses the mult/div unit
//   e_wa, e_tnew        E-stage destination (0 = none) and its Tnew
//   m_wa, m_tnew        M-stage destination (0 = none) and its Tnew
//   e_md_start          mult/div instruction in E this cycle
//   e_md_div            qualifies e_md_start: 1 = div/divu, 0 = mult/multu
//   pc_we, d_en         PC write enable, IF/ID enable (low while stalled)
//   e_clr               ID/EX synchronous clear (bubble insert)
//   md_busy             mult/div unit busy (registered)
//   stall_cnt           saturating count of stalled cycles
//
// Handshake: there is no valid/ready pair here; stall is a single-cycle,
// combinational hold request that the pipeline honours in the same cycle.
module stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic [1:0]  d_rs_tuse,
  input  logic [1:0]  d_rt_tuse,
  input  logic        d_is_md,
  input  logic [4:0]  e_wa,
  input  logic [1:0]  e_tnew,
  input  logic [4:0]  m_wa,
  input  logic [1:0]  m_tnew,
  input  logic        e_md_start,
  input  logic        e_md_div,
  output logic        pc_we,
  output logic        d_en,
  output logic        e_clr,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  // At least 4 bits, wider only when DIV_CYCLES needs it.
  localparam int CW = ($clog2(DIV_CYCLES + 1) > 4) ? $clog2(DIV_CYCLES + 1) : 4;

  logic [CW-1:0] md_cnt_q, md_cnt_d;
  logic [31:0]   stall_cnt_q, stall_cnt_d;

  logic stall_rs, stall_rt, stall_md, stall;

  always_comb begin
    stall_rs = (d_rs != 5'd0) && (d_rs_tuse != 2'd3) &&
               (((d_rs == e_wa) && (e_tnew > d_rs_tuse)) ||
                ((d_rs == m_wa) && (m_tnew > d_rs_tuse)));
    stall_rt = (d_rt != 5'd0) && (d_rt_tuse != 2'd3) &&
               (((d_rt == e_wa) && (e_tnew > d_rt_tuse)) ||
                ((d_rt == m_wa) && (m_tnew > d_rt_tuse)));
    // e_md_start covers the start cycle, before md_busy has risen.
    stall_md = d_is_md && (md_busy || e_md_start);
    // Reset forces the pipeline to free-run regardless of the inputs.
    stall    = !reset && (stall_rs || stall_rt || stall_md);
  end

  assign pc_we     = !stall;
  assign d_en      = !stall;
  assign e_clr     = stall;
  assign md_busy   = (md_cnt_q != '0);
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    md_cnt_d = md_cnt_q;
    // A start while busy is ignored; the running count keeps decrementing.
    if (e_md_start && (md_cnt_q == '0)) begin
      md_cnt_d = e_md_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt_q    <= '0;
      stall_cnt_q <= 32'd0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_stall_ctrl.sv
module tb_stall_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [4:0]  d_rs, d_rt, e_wa, m_wa;
  logic [1:0]  d_rs_tuse, d_rt_tuse, e_tnew, m_tnew;
  logic        d_is_md, e_md_start, e_md_div;
  logic        pc_we, d_en, e_clr, md_busy;
  logic [31:0] stall_cnt;

  stall_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset),
    .d_rs(d_rs), .d_rt(d_rt), .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse),
    .d_is_md(d_is_md), .e_wa(e_wa), .e_tnew(e_tnew), .m_wa(m_wa), .m_tnew(m_tnew),
    .e_md_start(e_md_start), .e_md_div(e_md_div),
    .pc_we(pc_we), .d_en(d_en), .e_clr(e_clr), .md_busy(md_busy),
    .stall_cnt(stall_cnt)
  );

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;

  // Model state: a cycle counter, the cycle number at which the mult/div
  // unit becomes free again, and the expected stall count.
  longint cyc      = 0;
  longint busy_end = 0;
  logic [31:0] exp_cnt = 32'd0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic bit src_hazard(input int r, input int tuse);
    if (r == 0 || tuse == 3) return 0;
    if (r == int'(e_wa) && int'(e_tnew) > tuse) return 1;
    if (r == int'(m_wa) && int'(m_tnew) > tuse) return 1;
    return 0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    d_rs = 0; d_rt = 0; d_rs_tuse = 3; d_rt_tuse = 3; d_is_md = 0;
    e_wa = 0; e_tnew = 0; m_wa = 0; m_tnew = 0;
    e_md_start = 0; e_md_div = 0;
  endtask

  // Runs one clock cycle with the inputs currently driven: checks every
  // output mid-cycle against the model, then advances the model at the edge.
  task automatic cycle(input string tag);
    bit busy, stall;
    if (reset) begin
      exp_cnt  = 32'd0;
      busy_end = cyc;
    end
    #2;
    busy  = (cyc < busy_end);
    stall = !reset && (src_hazard(int'(d_rs), int'(d_rs_tuse)) ||
                       src_hazard(int'(d_rt), int'(d_rt_tuse)) ||
                       (d_is_md && (busy || e_md_start)));
    check({tag, ".pc_we"},   32'(pc_we),   32'(!stall));
    check({tag, ".d_en"},    32'(d_en),    32'(!stall));
    check({tag, ".e_clr"},   32'(e_clr),   32'(stall));
    check({tag, ".md_busy"}, 32'(md_busy), 32'(busy));
    exp_q.push_back(exp_cnt);
    check({tag, ".stall_cnt"}, stall_cnt, exp_q.pop_front());
    @(posedge clk);
    cyc++;
    if (!reset) begin
      if (stall && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
      if (e_md_start && !busy) busy_end = cyc + (e_md_div ? DIV_N : MULT_N);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1;
    cycle("rst_pulse");
    reset = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    set_idle();
    reset = 1;
    // Reset held for two cycles with an md start and md instruction present.
    e_md_start = 1; d_is_md = 1;
    cycle("reset0");
    cycle("reset1");
    reset = 0; e_md_start = 0; d_is_md = 0;
    cycle("post_reset0");
    check("post_reset.md_busy", 32'(md_busy), 32'd0);
    cycle("post_reset1");

    // Load-use hazard on rs: E producer, then M producer, then resolved.
    d_rs = 5; d_rs_tuse = 0; e_wa = 5; e_tnew = 2;
    cycle("loaduse_e");
    e_wa = 0; e_tnew = 0; m_wa = 5; m_tnew = 1;
    cycle("loaduse_m");
    m_tnew = 0;
    cycle("loaduse_clear");
    check("loaduse.cnt", stall_cnt, 32'd2);
    set_idle();

    // $zero source and unread operand never stall.
    d_rs = 0; d_rs_tuse = 0; e_wa = 0; e_tnew = 2;
    cycle("zero_reg");
    d_rs = 0; d_rt = 7; d_rt_tuse = 3; e_wa = 7; e_tnew = 2;
    cycle("rt_unused");
    set_idle();

    // mult followed by mfhi held in D.
    do_reset();
    e_md_start = 1; e_md_div = 0; d_is_md = 1;
    cycle("mult_start");
    e_md_start = 0;
    for (int i = 0; i < MULT_N; i++) cycle($sformatf("mult_busy%0d", i));
    cycle("mult_issue");
    check("mult.pc_we", 32'(pc_we), 32'd1);
    check("mult.cnt", stall_cnt, 32'd6);
    set_idle();

    // div with a second start at busy cycle 3 (ignored).
    e_md_start = 1; e_md_div = 1;
    cycle("div_start");
    e_md_start = 0;
    for (int i = 1; i <= DIV_N + 1; i++) begin
      e_md_start = (i == 3);
      cycle($sformatf("div_busy%0d", i));
    end
    e_md_start = 0;

    // div interrupted by asynchronous reset at busy cycle 5.
    e_md_start = 1; e_md_div = 1;
    cycle("div2_start");
    e_md_start = 0;
    for (int i = 1; i <= 4; i++) cycle($sformatf("div2_busy%0d", i));
    reset = 1;
    #1;
    check("async_rst.md_busy", 32'(md_busy), 32'd0);
    check("async_rst.pc_we", 32'(pc_we), 32'd1);
    cycle("async_rst");
    reset = 0;
    cycle("after_async_rst");

    // Randomized traffic on a small register range to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      d_rs = 5'($urandom_range(0, 3)); d_rt = 5'($urandom_range(0, 3));
      d_rs_tuse = 2'($urandom_range(0, 3)); d_rt_tuse = 2'($urandom_range(0, 3));
      e_wa = 5'($urandom_range(0, 3)); e_tnew = 2'($urandom_range(0, 3));
      m_wa = 5'($urandom_range(0, 3)); m_tnew = 2'($urandom_range(0, 3));
      d_is_md = ($urandom_range(0, 3) == 0);
      e_md_start = ($urandom_range(0, 7) == 0);
      e_md_div = 1'($urandom_range(0, 1));
      cycle("rand");
    end
    set_idle();
    // Let any random busy period drain.
    for (int i = 0; i < DIV_N + 1; i++) cycle("drain");

    // Saturation: preload near the limit, then stall three cycles.
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    exp_cnt = 32'hFFFF_FFFE;
    d_rs = 9; d_rs_tuse = 0; e_wa = 9; e_tnew = 1;
    for (int i = 0; i < 3; i++) cycle($sformatf("sat%0d", i));
    set_idle();
    cycle("sat_hold");
    check("sat.final", stall_cnt, 32'hFFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
